// File: rtl/sram_bank_pipe_pkg.sv
// Package for the sram_bank_pipe storage bank.
//   wr_dout_e    : rsp_rdata behaviour when a write reaches the end of the read pipeline
//   sram_state_e : bank controller states
//   be_merge     : byte-lane merge of an old and a new byte under one enable bit
package sram_pkg;

  typedef enum logic [1:0] {HOLD, ZERO, THRU} wr_dout_e;

  typedef enum logic [0:0] {ST_INIT, ST_READY} sram_state_e;

  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_bank_pipe_if.sv
// Request/response bus of the sram_bank_pipe storage bank.
//   master : drives req_valid/req_we/req_addr/req_wdata/req_be, receives req_ready and rsp_*
//   slave  : the bank side
interface sram_bank_pipe_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [AW-1:0]         req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_bank_pipe_array.sv
// Storage array for sram_bank_pipe: one synchronous byte-enable write port and
// one synchronous read port, no reset. The read port returns the word as it was
// before a write on the same edge.
//   clk   : clock
//   we    : write strobe; waddr/wbe/wdata select the word and lanes
//   re    : read strobe; rdata holds mem[raddr] from the edge where re was high
module sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sram_bank_pipe.sv
// Generic single-port storage bank with byte-enable writes, a valid/ready
// request port and a read return pipeline of RD_LAT cycles.
//   clk       : clock, all state on posedge
//   reset_n   : asynchronous active-low reset
//   bus       : request/response bus (slave side)
//   init_done : high once the post-reset clear has finished
//
// state    | meaning
// ST_INIT  | writing INIT_VAL to one word per cycle, requests refused
// ST_READY | one request accepted per cycle
module sram_bank_pipe
  import sram_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 256,
  parameter int                RD_LAT       = 2,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0,
  parameter wr_dout_e          WR_DOUT_MODE = HOLD
) (
  input  logic               clk,
  input  logic               reset_n,
  sram_bank_pipe_if.slave    bus,
  output logic               init_done
);
  localparam int AW   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W = DATA_W / 8;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  if ((DATA_W % 8) != 0 || RD_LAT < 1 || RD_LAT > 4 || DEPTH < 2) begin : g_param_err
    $error("sram_bank_pipe: illegal DATA_W/RD_LAT/DEPTH");
  end

  sram_state_e       state;
  logic [AW-1:0]     clr_cnt;
  logic              acc;
  logic              in_rng;
  logic              arr_we;
  logic              arr_re;
  logic [AW-1:0]     arr_waddr;
  logic [BE_W-1:0]   arr_wbe;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [RD_LAT-1:0] we_q;
  logic [DATA_W-1:0] wd_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] tail_data;

  assign acc    = bus.req_valid & bus.req_ready;
  assign in_rng = ({1'b0, bus.req_addr} < DEPTH_C);
  // Every in-range access reads the array, so a write also captures the old
  // word needed for the merged (THRU) view.
  assign arr_re = acc & in_rng;

  // The clear sequence owns the write port while in ST_INIT; gating with
  // reset_n keeps reset itself from touching the contents.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = bus.req_addr;
    arr_wbe   = bus.req_be;
    arr_wdata = bus.req_wdata;
    if (state == ST_INIT) begin
      arr_we    = reset_n;
      arr_waddr = clr_cnt;
      arr_wbe   = '1;
      arr_wdata = INIT_VAL;
    end else begin
      arr_we    = acc & bus.req_we & in_rng;
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wbe   (arr_wbe),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (bus.req_addr),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= (CLEAR_ON_RST != 0) ? ST_INIT : ST_READY;
      clr_cnt       <= '0;
      bus.req_ready <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == LAST) begin
            state         <= ST_READY;
            bus.req_ready <= 1'b1;
            init_done     <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        default: begin
          bus.req_ready <= 1'b1;
          init_done     <= 1'b1;
        end
      endcase
    end
  end

  // Control pipeline: index 0 is the cycle after the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      err_q <= '0;
      we_q  <= '0;
      wd_q  <= '0;
      be_q  <= '0;
    end else begin
      vld_q[0] <= acc & ~bus.req_we;
      err_q[0] <= acc & ~bus.req_we & ~in_rng;
      we_q[0]  <= acc & bus.req_we & in_rng;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        we_q[i]  <= we_q[i-1];
      end
      if (acc & bus.req_we) begin
        wd_q <= bus.req_wdata;
        be_q <= bus.req_be;
      end
    end
  end

  for (genvar i = 0; i < BE_W; i++) begin : g_merge
    assign merged[8*i +: 8] = be_merge(arr_rdata[8*i +: 8], wd_q[8*i +: 8], be_q[i]);
  end

  assign s1_data = we_q[0] ? merged : (err_q[0] ? '0 : arr_rdata);

  if (RD_LAT == 1) begin : g_lat1
    assign tail_data = s1_data;
  end else begin : g_latn
    logic [DATA_W-1:0] dq [RD_LAT-1];
    always_ff @(posedge clk) begin
      dq[0] <= s1_data;
      for (int i = 1; i < RD_LAT - 1; i++) dq[i] <= dq[i-1];
    end
    assign tail_data = dq[RD_LAT-2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (vld_q[RD_LAT-1]) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= tail_data;
      bus.rsp_err   <= err_q[RD_LAT-1];
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      if (we_q[RD_LAT-1]) begin
        case (WR_DOUT_MODE)
          ZERO:    bus.rsp_rdata <= '0;
          THRU:    bus.rsp_rdata <= tail_data;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sram_bank_pipe.sv
// Directed bench for sram_bank_pipe with three configurations:
//   a : DEPTH 256, RD_LAT 2, clear on reset, HOLD
//   b : DEPTH 200, RD_LAT 2, clear on reset, ZERO
//   c : DEPTH 64,  RD_LAT 1, no clear,       THRU
module tb_sram_bank_pipe;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic done_a, done_b, done_c;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   stray;

  always #5 clk = ~clk;

  sram_bank_pipe_if #(.DATA_W(32), .AW(8)) if_a ();
  sram_bank_pipe_if #(.DATA_W(32), .AW(8)) if_b ();
  sram_bank_pipe_if #(.DATA_W(32), .AW(6)) if_c ();

  sram_bank_pipe #(.DATA_W(32), .DEPTH(256), .RD_LAT(2), .CLEAR_ON_RST(1),
                   .INIT_VAL(32'h0), .WR_DOUT_MODE(HOLD))
    u_a (.clk(clk), .reset_n(reset_n), .bus(if_a), .init_done(done_a));
  sram_bank_pipe #(.DATA_W(32), .DEPTH(200), .RD_LAT(2), .CLEAR_ON_RST(1),
                   .INIT_VAL(32'h0), .WR_DOUT_MODE(ZERO))
    u_b (.clk(clk), .reset_n(reset_n), .bus(if_b), .init_done(done_b));
  sram_bank_pipe #(.DATA_W(32), .DEPTH(64), .RD_LAT(1), .CLEAR_ON_RST(0),
                   .INIT_VAL(32'h0), .WR_DOUT_MODE(THRU))
    u_c (.clk(clk), .reset_n(reset_n), .bus(if_c), .init_done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if_a.req_valid = v; if_a.req_we = we; if_a.req_addr = addr;
    if_a.req_wdata = wd; if_a.req_be = be;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if_b.req_valid = v; if_b.req_we = we; if_b.req_addr = addr;
    if_b.req_wdata = wd; if_b.req_be = be;
  endtask

  task automatic set_c(input logic v, input logic we, input logic [5:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if_c.req_valid = v; if_c.req_we = we; if_c.req_addr = addr;
    if_c.req_wdata = wd; if_c.req_be = be;
  endtask

  initial begin
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    set_c(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    reset_n = 1'b0;
    repeat (3) tick();

    // reset values
    chk("rst_ready",     64'(if_a.req_ready), 64'd0);
    chk("rst_valid",     64'(if_a.rsp_valid), 64'd0);
    chk("rst_rdata",     64'(if_a.rsp_rdata), 64'd0);
    chk("rst_err",       64'(if_a.rsp_err),   64'd0);
    chk("rst_init_done", 64'(done_a),         64'd0);

    reset_n = 1'b1;
    tick();
    chk("c_ready_no_clear", 64'(if_c.req_ready), 64'd1);
    chk("c_done_no_clear",  64'(done_c),         64'd1);
    n = 1;
    while (if_a.req_ready !== 1'b1 && n < 400) begin tick(); n++; end
    chk("a_init_cycles", 64'(n), 64'd256);
    chk("a_init_done",   64'(done_a), 64'd1);
    chk("b_init_done",   64'(done_b), 64'd1);

    // test 1: cleared word reads zero, two cycles after accept
    set_a(1'b1, 1'b0, 8'h80, 32'h0, 4'h0); tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); chk("t1_not_early", 64'(if_a.rsp_valid), 64'd0);
    tick(); chk("t1_valid", 64'(if_a.rsp_valid), 64'd1);
    chk("t1_rdata", 64'(if_a.rsp_rdata), 64'd0);
    chk("t1_err",   64'(if_a.rsp_err),   64'd0);
    tick(); chk("t1_one_pulse", 64'(if_a.rsp_valid), 64'd0);

    // test 2: byte-enable merge, read right after write
    set_a(1'b1, 1'b1, 8'h80, 32'hDEADBEEF, 4'hF); tick();
    set_a(1'b1, 1'b1, 8'h80, 32'h00001100, 4'h2); tick();
    set_a(1'b1, 1'b0, 8'h80, 32'h0, 4'h0);        tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); chk("t2_no_wr_pulse", 64'(if_a.rsp_valid), 64'd0);
    tick(); chk("t2_valid", 64'(if_a.rsp_valid), 64'd1);
    chk("t2_merge", 64'(if_a.rsp_rdata), 64'hDEAD11EF);
    set_a(1'b1, 1'b1, 8'h80, 32'hFFFFFFFF, 4'h0); tick();
    set_a(1'b1, 1'b0, 8'h80, 32'h0, 4'h0);        tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); tick(); chk("t2_be0_noop", 64'(if_a.rsp_rdata), 64'hDEAD11EF);
    set_a(1'b1, 1'b1, 8'hFF, 32'h12345678, 4'hF); tick();
    set_a(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0);        tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); tick(); chk("t2_last_addr", 64'(if_a.rsp_rdata), 64'h12345678);

    // test 3: back-to-back reads return in order
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, 8'(i), 32'(10 + i), 4'hF); tick();
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_a(1'b1, 1'b0, 8'(i), 32'h0, 4'h0);
      else       set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
      tick();
      if (i >= 2 && i <= 5) begin
        chk($sformatf("t3_valid%0d", i), 64'(if_a.rsp_valid), 64'd1);
        chk($sformatf("t3_data%0d", i),  64'(if_a.rsp_rdata), 64'(10 + i - 2));
      end else begin
        chk($sformatf("t3_idle%0d", i),  64'(if_a.rsp_valid), 64'd0);
      end
    end

    // test 5: write after read, HOLD (a) and ZERO (b)
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin set_a(1'b1, 1'b1, 8'h10, 32'h55, 4'hF); set_b(1'b1, 1'b1, 8'h10, 32'h55, 4'hF); end
        1: begin set_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);  set_b(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);  end
        2: begin set_a(1'b1, 1'b1, 8'h10, 32'hAA, 4'hF); set_b(1'b1, 1'b1, 8'h10, 32'hAA, 4'hF); end
        default: begin set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0); set_b(1'b0, 1'b0, 8'h0, 32'h0, 4'h0); end
      endcase
      tick();
      if (i == 3) begin
        chk("t5_a_rd_valid", 64'(if_a.rsp_valid), 64'd1);
        chk("t5_a_rd_data",  64'(if_a.rsp_rdata), 64'h55);
        chk("t5_b_rd_valid", 64'(if_b.rsp_valid), 64'd1);
        chk("t5_b_rd_data",  64'(if_b.rsp_rdata), 64'h55);
      end
      if (i == 4) begin
        chk("t5_a_wr_novalid", 64'(if_a.rsp_valid), 64'd0);
        chk("t5_a_hold",       64'(if_a.rsp_rdata), 64'h55);
        chk("t5_b_wr_novalid", 64'(if_b.rsp_valid), 64'd0);
        chk("t5_b_zero",       64'(if_b.rsp_rdata), 64'h0);
      end
    end
    set_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0); tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); tick(); chk("t5_a_array_new", 64'(if_a.rsp_rdata), 64'hAA);

    // test 5: THRU with RD_LAT 1 (c)
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_c(1'b1, 1'b1, 6'h10, 32'h55, 4'hF);
        1: set_c(1'b1, 1'b0, 6'h10, 32'h0, 4'h0);
        2: set_c(1'b1, 1'b1, 6'h10, 32'hAA, 4'hF);
        default: set_c(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
      endcase
      tick();
      if (i == 1) begin
        chk("t5_c_w1_novalid", 64'(if_c.rsp_valid), 64'd0);
        chk("t5_c_w1_thru",    64'(if_c.rsp_rdata), 64'h55);
      end
      if (i == 2) begin
        chk("t5_c_rd_valid", 64'(if_c.rsp_valid), 64'd1);
        chk("t5_c_rd_data",  64'(if_c.rsp_rdata), 64'h55);
      end
      if (i == 3) begin
        chk("t5_c_w2_novalid", 64'(if_c.rsp_valid), 64'd0);
        chk("t5_c_w2_thru",    64'(if_c.rsp_rdata), 64'hAA);
      end
    end

    // test 4: DEPTH 200 boundary and out-of-range access (b)
    set_b(1'b1, 1'b1, 8'd199, 32'h77, 4'hF); tick();
    set_b(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);  tick();
    set_b(1'b1, 1'b0, 8'd200, 32'h0, 4'h0);  tick();
    set_b(1'b1, 1'b0, 8'd250, 32'h0, 4'h0);  tick();
    chk("t4_199_valid", 64'(if_b.rsp_valid), 64'd1);
    chk("t4_199_data",  64'(if_b.rsp_rdata), 64'h77);
    chk("t4_199_err",   64'(if_b.rsp_err),   64'd0);
    set_b(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick();
    chk("t4_200_valid", 64'(if_b.rsp_valid), 64'd1);
    chk("t4_200_err",   64'(if_b.rsp_err),   64'd1);
    chk("t4_200_data",  64'(if_b.rsp_rdata), 64'h0);
    tick();
    chk("t4_250_valid", 64'(if_b.rsp_valid), 64'd1);
    chk("t4_250_err",   64'(if_b.rsp_err),   64'd1);
    chk("t4_250_data",  64'(if_b.rsp_rdata), 64'h0);
    tick();
    chk("t4_err_clear", 64'({if_b.rsp_valid, if_b.rsp_err}), 64'd0);
    set_b(1'b1, 1'b1, 8'd250, 32'hFFFFFFFF, 4'hF); tick();
    set_b(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_b.rsp_valid !== 1'b0 || if_b.rsp_err !== 1'b0) stray++;
    end
    chk("t4_oor_wr_silent", 64'(stray), 64'd0);
    set_b(1'b1, 1'b0, 8'd50, 32'h0, 4'h0); tick();
    set_b(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); tick();
    chk("t4_alias_valid", 64'({if_b.rsp_valid, if_b.rsp_err}), 64'd2);
    chk("t4_alias_data",  64'(if_b.rsp_rdata), 64'h0);

    // contents survive reset without clear (c)
    set_c(1'b1, 1'b1, 6'h05, 32'hCAFE0005, 4'hF); tick();
    set_c(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);

    // test 6: reset with reads in flight, then reset mid-INIT
    set_a(1'b1, 1'b0, 8'h80, 32'h0, 4'h0); tick();
    set_a(1'b1, 1'b0, 8'h81, 32'h0, 4'h0); tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    reset_n = 1'b0;
    tick();
    chk("t6_drop_valid", 64'(if_a.rsp_valid), 64'd0);
    chk("t6_done_low",   64'(done_a),         64'd0);
    tick();
    reset_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (if_a.rsp_valid !== 1'b0) stray++;
    end
    chk("t6_no_late_valid", 64'(stray), 64'd0);
    chk("t6_mid_init_ready", 64'(if_a.req_ready), 64'd0);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n = 1;
    while (if_a.req_ready !== 1'b1 && n < 400) begin tick(); n++; end
    chk("t6_init_restart_cycles", 64'(n), 64'd256);
    set_a(1'b1, 1'b0, 8'h80, 32'h0, 4'h0); tick();
    set_a(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    tick(); tick();
    chk("t6_cleared_valid", 64'(if_a.rsp_valid), 64'd1);
    chk("t6_cleared_data",  64'(if_a.rsp_rdata), 64'h0);

    set_c(1'b1, 1'b0, 6'h05, 32'h0, 4'h0); tick();
    set_c(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    tick();
    chk("t6_c_keep_valid", 64'(if_c.rsp_valid), 64'd1);
    chk("t6_c_keep_data",  64'(if_c.rsp_rdata), 64'hCAFE0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
